// File: rtl/ro_counter_axil_slave_if.sv
// AXI4-Lite bus bundle for the ring-oscillator counter slave.
// Signal names match the AXI4-Lite port names so the bus reads the same at either end.
interface ro_counter_axil_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/ro_counter_axil_slave.sv
// AXI4-Lite slave counting rising edges of a divided ring-oscillator tap over a
// software-programmed gate window; registers CTRL/WINDOW/COUNT/STATUS at 0x0..0xC.
module ro_counter_axil_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int          CNT_WIDTH          = 32,
  parameter logic [31:0] WINDOW_RESET       = 32'd1000
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  ro_counter_axil_slave_if.slave s_axi,
  input  logic                   ro_in,
  output logic                   meas_done,
  output logic                   dbg_state
);

  // Handshake contract on every channel: a transfer happens on the clock edge where
  // VALID and READY are both high; VALID, once raised, holds with its payload until then.

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } state_e;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_WINDOW = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic                          aw_ready_q, aw_ready_d;
  logic                          b_valid_q, b_valid_d;
  logic                          ar_ready_q, ar_ready_d;
  logic                          r_valid_q, r_valid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                          cont_q, cont_d;
  logic [31:0]                   window_q, window_d;
  logic [CNT_WIDTH-1:0]          count_q, count_d;
  logic                          done_q, done_d;
  logic                          ovf_q, ovf_d;
  state_e                        state_q, state_d;
  logic [31:0]                   win_cnt_q, win_cnt_d;
  logic [CNT_WIDTH-1:0]          edge_cnt_q, edge_cnt_d;
  logic                          meas_done_q, meas_done_d;
  logic [2:0]                    sync_q, sync_d;

  logic                          wr_en, rd_en;
  logic [1:0]                    wr_addr;
  logic                          ctrl_wr, start_req, clear_req;
  logic                          ro_edge, cnt_sat, ovf_hit, busy;
  logic [CNT_WIDTH-1:0]          cnt_inc;
  logic [31:0]                   load_win;
  logic [31:0]                   count_ext;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
  logic                          unused_bits;

  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // ---------------- write channel ----------------
  assign wr_en     = aw_ready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign wr_addr   = s_axi.S_AXI_AWADDR[3:2];
  assign ctrl_wr   = wr_en & (wr_addr == A_CTRL) & s_axi.S_AXI_WSTRB[0];
  assign start_req = ctrl_wr & s_axi.S_AXI_WDATA[0];
  assign clear_req = ctrl_wr & s_axi.S_AXI_WDATA[1];

  always_comb begin
    aw_ready_d = ~aw_ready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~b_valid_q;
    b_valid_d  = b_valid_q;
    if (wr_en) begin
      b_valid_d = 1'b1;
    end else if (s_axi.S_AXI_BREADY) begin
      b_valid_d = 1'b0;
    end
    cont_d = cont_q;
    if (ctrl_wr) begin
      cont_d = s_axi.S_AXI_WDATA[2];
    end
    window_d = window_q;
    if (wr_en && wr_addr == A_WINDOW) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi.S_AXI_WSTRB[b]) begin
          window_d[8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  // ---------------- read channel ----------------
  assign rd_en = ar_ready_q & s_axi.S_AXI_ARVALID;
  assign busy  = (state_q == ST_GATE);

  always_comb begin
    count_ext = '0;
    count_ext[CNT_WIDTH-1:0] = count_q;
  end

  always_comb begin
    rd_mux = '0;
    case (s_axi.S_AXI_ARADDR[3:2])
      A_CTRL:   rd_mux[2] = cont_q;
      A_WINDOW: rd_mux = window_q;
      A_COUNT:  rd_mux = count_ext;
      A_STATUS: rd_mux[2:0] = {ovf_q, done_q, busy};
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    ar_ready_d = ~ar_ready_q & s_axi.S_AXI_ARVALID & ~r_valid_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    if (rd_en) begin
      r_valid_d = 1'b1;
      r_data_d  = rd_mux;
    end else if (s_axi.S_AXI_RREADY) begin
      r_valid_d = 1'b0;
    end
  end

  // ---------------- edge detect and measurement FSM ----------------
  assign sync_d   = {sync_q[1:0], ro_in};
  assign ro_edge  = sync_q[1] & ~sync_q[2];
  assign cnt_sat  = &edge_cnt_q;
  assign ovf_hit  = ro_edge & cnt_sat;
  assign cnt_inc  = (ro_edge && !cnt_sat) ? edge_cnt_q + CNT_WIDTH'(1) : edge_cnt_q;
  assign load_win = (window_q == 32'd0) ? 32'd1 : window_q;

  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    count_d     = count_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    meas_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d    = ST_GATE;
          win_cnt_d  = load_win;
          edge_cnt_d = '0;
          done_d     = 1'b0;
          ovf_d      = 1'b0;
        end
      end
      ST_GATE: begin
        edge_cnt_d = cnt_inc;
        ovf_d      = ovf_q | ovf_hit;
        win_cnt_d  = win_cnt_q - 32'd1;
        if (win_cnt_q == 32'd1) begin
          count_d     = cnt_inc;
          done_d      = 1'b1;
          meas_done_d = 1'b1;
          // Continuous mode restarts the gate back-to-back with the current WINDOW.
          if (cont_q) begin
            win_cnt_d  = load_win;
            edge_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear_req) begin
      state_d     = ST_IDLE;
      win_cnt_d   = '0;
      edge_cnt_d  = '0;
      count_d     = '0;
      done_d      = 1'b0;
      ovf_d       = 1'b0;
      meas_done_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_ready_q  <= 1'b0;
      b_valid_q   <= 1'b0;
      ar_ready_q  <= 1'b0;
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
      cont_q      <= 1'b0;
      window_q    <= WINDOW_RESET;
      count_q     <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      state_q     <= ST_IDLE;
      win_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      meas_done_q <= 1'b0;
      sync_q      <= '0;
    end else begin
      aw_ready_q  <= aw_ready_d;
      b_valid_q   <= b_valid_d;
      ar_ready_q  <= ar_ready_d;
      r_valid_q   <= r_valid_d;
      r_data_q    <= r_data_d;
      cont_q      <= cont_d;
      window_q    <= window_d;
      count_q     <= count_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      meas_done_q <= meas_done_d;
      sync_q      <= sync_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = aw_ready_q;
  assign s_axi.S_AXI_WREADY  = aw_ready_q;
  assign s_axi.S_AXI_BVALID  = b_valid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = ar_ready_q;
  assign s_axi.S_AXI_RVALID  = r_valid_q;
  assign s_axi.S_AXI_RDATA   = r_data_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign meas_done           = meas_done_q;
  assign dbg_state           = state_q;

endmodule

// File: doc/ro_counter_axil_slave.md
Name: ro_counter_axil_slave

Overview:
- AXI4-Lite slave that owns one ring-oscillator edge-count sensor. It is the responder end of the AXI4-Lite master traffic issued from the processor or VIP master.
- A software-programmed gate window, measured in clock cycles, controls the count. The block counts rising edges of a ring-oscillator tap that has been divided down externally and sampled as data.
- Results, status and control are exposed as four 32-bit registers at word offsets 0x0, 0x4, 0x8 and 0xC.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, AXI address width. Decode uses ADDR[3:2].
- CNT_WIDTH, 32, edge-counter width, 1..32. Zero-extended into COUNT.
- WINDOW_RESET, 1000, reset value of the WINDOW register.

Ports:
- S_AXI_ACLK in 1: single clock. Everything is in this domain.
- S_AXI_ARESETN in 1: asynchronous active-low reset.
- S_AXI_AWADDR in 4; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
- S_AXI_ARADDR in 4; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
- ro_in in 1: divided ring-oscillator tap, asynchronous to S_AXI_ACLK.
- meas_done out 1: one-cycle pulse when a measurement completes.

Behaviour:
- Reset values of outputs: all READY, VALID and RDATA outputs are 0; BRESP and RRESP are 00; meas_done is 0.
- Reset values of registers: CTRL.CONT=0, WINDOW=WINDOW_RESET, COUNT=0, STATUS=0. FSM is in IDLE. Synchronizer flops are 0.
- Write channel:
  - AWREADY and WREADY pulse high together for one cycle when AWVALID and WVALID are both high, BVALID is low, and the ready outputs are currently low.
  - On that edge the register is updated, honouring WSTRB per byte for WINDOW and byte 0 of CTRL. BVALID rises on the same edge.
  - BVALID holds until BREADY. Only one write is outstanding at a time.
  - BRESP is always 00 (OKAY). Writes to COUNT or STATUS are discarded.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID is high and RVALID is low.
  - RDATA and RVALID are registered on the next edge and held stable until RREADY. RRESP is always 00.
  - Reads and writes are independent and may complete in the same cycle.
- Register map:
  - 0x0 CTRL. bit0 START: write-1, self-clearing, reads 0. bit1 CLEAR: write-1, self-clearing, reads 0. bit2 CONT: read/write. Other bits read 0.
  - 0x4 WINDOW: read/write, 32 bits. A value of 0 behaves as 1.
  - 0x8 COUNT: read-only. Holds the last completed count.
  - 0xC STATUS: read-only. bit0 BUSY, bit1 DONE (sticky), bit2 OVF (sticky). Other bits 0.
- Edge detect:
  - ro_in passes through a 2-flop synchronizer, then a third flop.
  - edge = s2 & ~s3, giving at most one edge per cycle.
  - Input pulses narrower than one clock cycle may be missed; this is accepted.
- FSM states: IDLE, GATE.
  - IDLE -> GATE on the cycle after a START write. On entry the window counter is loaded with max(WINDOW,1), the edge counter is cleared, DONE and OVF are cleared, and BUSY is set.
  - GATE lasts exactly max(WINDOW,1) cycles. Every edge in those cycles increments the edge counter, which saturates at 2^CNT_WIDTH-1 and sets OVF on an attempted increment past saturation.
  - On the last GATE cycle's edge, COUNT is loaded with the final count including that cycle's edge, DONE is set, and meas_done pulses.
  - After the last GATE cycle the FSM goes to IDLE (BUSY=0) if CONT=0. If CONT=1 it re-enters GATE immediately with a fresh load, and BUSY stays 1.
- Boundary rules:
  - START while BUSY is ignored.
  - CLEAR in any state forces IDLE and zeroes COUNT, DONE, OVF and BUSY on the write edge. CLEAR wins over a simultaneous START.
  - A WINDOW write during GATE affects only the next measurement.
  - A COUNT read in the same cycle as a COUNT update returns the old value.
  - Asynchronous reset mid-transaction drops all handshakes immediately. No response is owed for an interrupted transaction.

Test Plan:
- Reset, then read 0x4, 0x8 and 0xC → 0x000003E8, 0x00000000, 0x00000000, all with RRESP=00.
- Write WINDOW=100; drive ro_in with period 10 cycles (5 high, 5 low); write CTRL=0x1 → STATUS=0x1 while gating, then meas_done pulses once, COUNT=10 and STATUS=0x2.
- Write 0xAABBCCDD to 0x4 with WSTRB=0001 after reset → WINDOW reads 0x000003DD. Write 0x5 to 0x8 → BRESP=00 and COUNT is unchanged.
- With CNT_WIDTH=4, WINDOW=200, ro_in period 10 (20 edges), START → COUNT=0x0000000F and STATUS=0x6.
- Write CTRL=0x4 (CONT) then CTRL=0x5 with WINDOW=50 and ro_in period 10 → meas_done pulses every 50 cycles and each COUNT=5. Write CTRL=0x2 mid-window → STATUS=0 and COUNT=0 on the next read.
- Hold RREADY low for 5 cycles on a COUNT read, and hold BREADY low for 3 cycles on a write → RDATA/RVALID and BVALID stay stable, and no new ARREADY or AWREADY is asserted until the handshake completes.
